// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: shared constants, FSM state encoding and width helper for the 7-segment scanner
package seg7_scan_driver_pkg;
    localparam logic [6:0] SEG7_OFF        = 7'h7F;
    localparam int         SEG7_DIGITS_DEF = 6;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } seg7_state_t;

    function automatic int seg7_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: BLANK/SHOW dwell counter and digit index; exposes next-cycle state so the
// top can register its outputs on the same edge as the state change.
module seg7_scan_timer
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS    = SEG7_DIGITS_DEF,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    output logic                          o_show_nxt,
    output logic [seg7_idx_w(DIGITS)-1:0] o_idx_nxt,
    output logic                          o_frame_start
);
    localparam int IW = seg7_idx_w(DIGITS);
    localparam int CW = $clog2(((SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC) + 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYC == 0) ? '0 : CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    seg7_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic          w_adv;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= IDX_LAST;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // With no blanking gap, SHOW chains straight into the next digit's SHOW.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_adv       = 1'b0;
        if (r_state == ST_BLANK) begin
            if (r_cnt == BLANK_LAST) begin
                w_state_nxt = ST_SHOW;
                w_adv       = 1'b1;
            end
        end else if (r_cnt == SHOW_LAST) begin
            w_state_nxt = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
            w_adv       = (BLANK_CYC == 0);
        end
        if (w_state_nxt != r_state || w_adv)
            w_cnt_nxt = '0;
        w_idx_nxt = w_adv ? ((r_idx == IDX_LAST) ? '0 : r_idx + 1'b1) : r_idx;
    end

    assign o_show_nxt    = (w_state_nxt == ST_SHOW);
    assign o_idx_nxt     = w_idx_nxt;
    assign o_frame_start = w_adv && (w_idx_nxt == '0);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment scanner with per-frame input snapshot.
// Define SEG7_OVERLOAD_BLINK_EN to blink the display while the snapshotted overload flag is set.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS       = SEG7_DIGITS_DEF,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7*DIGITS-1:0]   segments_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  overload,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     anode_n
);
    localparam int IW = seg7_idx_w(DIGITS);

    logic                w_show_nxt;
    logic                w_frame_start;
    logic [IW-1:0]       w_idx_nxt;
    logic [7*DIGITS-1:0] r_snap_seg, w_seg_src;
    logic [DIGITS-1:0]   r_snap_dp, w_dp_src;
    logic                w_dark_nxt;

    seg7_scan_timer #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .i_clk         (clock),
        .i_rst_n       (reset),
        .o_show_nxt    (w_show_nxt),
        .o_idx_nxt     (w_idx_nxt),
        .o_frame_start (w_frame_start)
    );

    // Digit 0 of a new frame reads the live inputs; every later digit reads the snapshot.
    assign w_seg_src = w_frame_start ? segments_in : r_snap_seg;
    assign w_dp_src  = w_frame_start ? dp_in : r_snap_dp;

`ifdef SEG7_OVERLOAD_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] r_frame_cnt;
    logic          r_blink_phase;
    logic          r_snap_dark;

    // A frame is dark when overload was set at its start and the phase held then was 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_snap_dark   <= 1'b0;
        end else if (w_frame_start) begin
            r_snap_dark <= overload & r_blink_phase;
            if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_dark_nxt = w_frame_start ? (overload & r_blink_phase) : r_snap_dark;
`else
    assign w_dark_nxt = overload && (BLINK_FRAMES < 1);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_n      <= SEG7_OFF;
            dp_n       <= 1'b1;
            anode_n    <= '1;
            r_snap_seg <= '1;
            r_snap_dp  <= '1;
        end else begin
            if (w_frame_start) begin
                r_snap_seg <= segments_in;
                r_snap_dp  <= dp_in;
            end
            seg_n   <= w_show_nxt ? w_seg_src[7*w_idx_nxt +: 7] : SEG7_OFF;
            dp_n    <= w_show_nxt ? w_dp_src[w_idx_nxt] : 1'b1;
            anode_n <= (w_show_nxt && !w_dark_nxt) ? ~(DIGITS'(1) << w_idx_nxt) : '1;
        end
    end
endmodule
